// File: rtl/phase_timer_pkg.sv
// Shared types and defaults for the phase timer: FSM state encoding,
// default clock rate and counter width, and the prescaler width helper.
package phase_timer_pkg;

  localparam int TICKS_PER_SEC_DEF = 10000;
  localparam int SEC_W_DEF         = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // clog2 of the tick count, floored at one bit so a 1-tick-per-second
  // build still gets a legal counter vector.
  function automatic int cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/phase_timer_if.sv
// Control/status bundle between a phase timer and whoever drives it.
// The master side issues commands; the slave side is the timer itself.
interface phase_timer_if #(
  parameter int SEC_W = phase_timer_pkg::SEC_W_DEF
);

  logic             start;
  logic [SEC_W-1:0] seconds;
  logic             pause;
  logic             abort;
  logic             finished;
  logic             done_pulse;
  logic [SEC_W-1:0] remaining;
  logic             busy;

  modport master (
    output start, seconds, pause, abort,
    input  finished, done_pulse, remaining, busy
  );

  modport slave (
    input  start, seconds, pause, abort,
    output finished, done_pulse, remaining, busy
  );

endinterface

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-second strobe: counts 0..TICKS-1 while enabled
// and raises sec_tick for the single cycle in which the count wraps.
module sec_prescaler
  import phase_timer_pkg::*;
#(
  parameter int TICKS = TICKS_PER_SEC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic sec_tick
);

  localparam int               CNT_W = cnt_width(TICKS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sec_tick = en && (cnt_q == LAST);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Countdown timer for one phase of whole seconds: IDLE/COUNT FSM, the
// seconds-remaining counter and registered status outputs.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int SEC_W         = SEC_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  phase_timer_if.slave tif
);

  state_e           state_q,     state_d;
  logic [SEC_W-1:0] remaining_q, remaining_d;
  logic             finished_q,  finished_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  logic sec_tick;
  logic pre_clr;
  logic pre_en;

  // Prescaler is parked at zero in IDLE so every load starts a fresh second.
  assign pre_clr = (state_q == IDLE) || tif.abort;
  assign pre_en  = (state_q == COUNT) && !tif.pause;

  sec_prescaler #(
    .TICKS (TICKS_PER_SEC)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (pre_clr),
    .en       (pre_en),
    .sec_tick (sec_tick)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // abort beats a simultaneous start; a zero-length phase expires at once
        if (tif.start && !tif.abort) begin
          if (tif.seconds != '0) begin
            state_d     = COUNT;
            remaining_d = tif.seconds;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      COUNT: begin
        if (tif.abort) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (sec_tick) begin
          if (remaining_q == SEC_W'(1)) begin
            state_d     = IDLE;
            remaining_d = '0;
            done_d      = 1'b1;
          end else begin
            remaining_d = remaining_q - SEC_W'(1);
          end
        end
      end

      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase

    finished_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      finished_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      finished_q  <= finished_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tif.finished   = finished_q;
  assign tif.busy       = busy_q;
  assign tif.done_pulse = done_q;
  assign tif.remaining  = remaining_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer at 10 ticks per second: a vector table for
// single-edge behaviour plus whole-phase runs with closed-form expectations.
module tb_phase_timer;

  localparam int TPS = 10;
  localparam int SW  = 16;
  localparam int NV  = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  phase_timer_if #(.SEC_W(SW)) tif ();

  phase_timer #(
    .TICKS_PER_SEC (TPS),
    .SEC_W         (SW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tif   (tif)
  );

  typedef struct {
    logic          rst;
    logic          start;
    logic [SW-1:0] secs;
    logic          pause;
    logic          abort;
    logic          fin;
    logic          done;
    logic [SW-1:0] rem;
  } vec_t;

  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic fin, input logic [SW-1:0] rem,
                            input logic done);
    check({tag, " finished"},   32'(tif.finished),   32'(fin));
    check({tag, " busy"},       32'(tif.busy),       32'(!fin));
    check({tag, " done_pulse"}, 32'(tif.done_pulse), 32'(done));
    check({tag, " remaining"},  32'(tif.remaining),  32'(rem));
  endtask

  task automatic drive(input logic r, input logic st, input logic [SW-1:0] secs,
                       input logic p, input logic a);
    reset       = r;
    tif.start   = st;
    tif.seconds = secs;
    tif.pause   = p;
    tif.abort   = a;
  endtask

  // Advance one edge and settle just past it before sampling outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One phase of s seconds; pause high for edges [ps, ps+pl); optional abort
  // (cut_kind=1) or reset (cut_kind=2) at edge cut_at; optional restart on
  // the cycle after done_pulse. Edge 0 is the start edge. A start with
  // seconds=9 is always offered at edge 3 and must be ignored.
  task automatic run_phase(input string tag, input int s, input int ps, input int pl,
                           input int cut_at, input int cut_kind, input int restart_s);
    int    e;
    int    inc;
    int    paused;
    bit    stop;
    bit    p;
    string name;
    e      = s * TPS + pl;
    paused = 0;
    stop   = 1'b0;
    drive(1'b0, 1'b1, SW'(s), 1'b0, 1'b0);
    tick();
    check_outs({tag, " k=0"}, 1'b0, SW'(s), 1'b0);
    for (int k = 1; k <= e && !stop; k++) begin
      p = (k >= ps) && (k < ps + pl);
      drive(cut_kind == 2 && k == cut_at, k == 3, (k == 3) ? SW'(9) : SW'(0), p,
            cut_kind == 1 && k == cut_at);
      tick();
      if (p) paused++;
      name = $sformatf("%s k=%0d", tag, k);
      if (cut_kind != 0 && k == cut_at) begin
        check_outs(name, 1'b1, '0, 1'b0);
        stop = 1'b1;
      end else begin
        inc = k - paused;
        if (inc >= s * TPS) begin
          check_outs(name, 1'b1, '0, 1'b1);
          stop = 1'b1;
        end else begin
          check_outs(name, 1'b0, SW'(s - inc / TPS), 1'b0);
        end
      end
    end
    if (restart_s > 0) begin
      drive(1'b0, 1'b1, SW'(restart_s), 1'b0, 1'b0);
      tick();
      check_outs({tag, " restart"}, 1'b0, SW'(restart_s), 1'b0);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      tick();
      check_outs({tag, " restart abort"}, 1'b1, '0, 1'b0);
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    check_outs({tag, " settle"}, 1'b1, '0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst   start  secs    pause abort   fin   done  rem
    vecs[0]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0,  1'b1, 1'b0, 16'd0}; // reset values
    vecs[1]  = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b0,  1'b1, 1'b1, 16'd0}; // S=0 -> pulse
    vecs[2]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0,  1'b1, 1'b0, 16'd0}; // pulse is 1 cycle
    vecs[3]  = '{1'b0, 1'b1, 16'd5, 1'b0, 1'b1,  1'b1, 1'b0, 16'd0}; // abort beats start
    vecs[4]  = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0,  1'b1, 1'b0, 16'd0}; // pause in IDLE
    vecs[5]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'd0}; // abort in IDLE
    vecs[6]  = '{1'b0, 1'b1, 16'd2, 1'b0, 1'b0,  1'b0, 1'b0, 16'd2}; // load S=2
    vecs[7]  = '{1'b0, 1'b1, 16'd9, 1'b0, 1'b0,  1'b0, 1'b0, 16'd2}; // start ignored
    vecs[8]  = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0,  1'b0, 1'b0, 16'd2}; // pause in COUNT
    vecs[9]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'd0}; // abort in COUNT
    vecs[10] = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'd0}; // abort kills S=0 pulse
    vecs[11] = '{1'b0, 1'b1, 16'd1, 1'b0, 1'b0,  1'b0, 1'b0, 16'd1}; // load S=1
    vecs[12] = '{1'b1, 1'b1, 16'd3, 1'b0, 1'b0,  1'b1, 1'b0, 16'd0}; // reset dominates
    vecs[13] = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b0,  1'b1, 1'b1, 16'd0}; // S=0 pulse
    vecs[14] = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b0,  1'b1, 1'b1, 16'd0}; // S=0 back-to-back
    vecs[15] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0,  1'b1, 1'b0, 16'd0}; // quiet

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].secs, vecs[i].pause, vecs[i].abort);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].fin, vecs[i].rem, vecs[i].done);
    end

    run_phase("s3",        3, 1000, 0,  0, 0, 0);
    run_phase("pause",     2,    4, 5,  0, 0, 0);
    run_phase("abort",     4, 1000, 0, 12, 1, 0);
    run_phase("reset",     5, 1000, 0,  7, 2, 0);
    run_phase("b2b",       1, 1000, 0,  0, 0, 2);
    run_phase("abort_exp", 1, 1000, 0, 10, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 10000, clk cycles per second (10 kHz clock).
REQ-002 Parameter SEC_W, default 16, width of seconds and remaining.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  load request, sampled on the clk edge.
REQ-006 seconds  in  SEC_W  phase duration in whole seconds, sampled with start.
REQ-007 pause  in  1  freezes counting while high.
REQ-008 abort  in  1  cancels the running phase.
REQ-009 finished  out  1  level: high when idle or expired, low while counting.
REQ-010 done_pulse  out  1  one-cycle strobe on natural expiry only.
REQ-011 remaining  out  SEC_W  seconds left, including the current partial second.
REQ-012 busy  out  1  equals NOT finished.

Function
REQ-013 All outputs shall be registered.
REQ-014 The FSM shall have two states: IDLE (finished=1) and COUNT (finished=0).
REQ-015 In IDLE, start=1 with seconds=S>0 shall load remaining=S, clear the prescaler, and enter COUNT at the next edge.
REQ-016 In IDLE, start=1 with S=0 shall stay in IDLE, keep finished=1, and assert done_pulse for exactly the next cycle.
REQ-017 In COUNT, start shall be ignored and seconds shall not be resampled.
REQ-018 The prescaler shall count 0..TICKS_PER_SEC-1 in COUNT when pause=0; at wrap, remaining shall decrement by 1.
REQ-019 When remaining goes 1->0, the FSM shall return to IDLE, set finished=1, and assert done_pulse for that one cycle, all at the same edge.
REQ-020 Timing: finished shall be low for exactly S*TICKS_PER_SEC + P cycles after the start edge, where P is the number of cycles with pause=1 during COUNT.
REQ-021 pause=1 shall hold the prescaler and remaining unchanged. pause shall have no effect in IDLE.
REQ-022 abort=1 in COUNT shall give IDLE, finished=1, remaining=0, and done_pulse=0 at the next edge.
REQ-023 Simultaneous abort and start in IDLE: abort wins, the load is dropped, and the block stays in IDLE.
REQ-024 Abort at the expiry edge: abort wins and done_pulse is suppressed.
REQ-025 A start in the cycle after done_pulse shall be accepted; there is no dead cycle.
REQ-026 remaining shall read 0 in IDLE.
REQ-027 The prescaler width shall be clog2(TICKS_PER_SEC), and it shall never exceed TICKS_PER_SEC-1.

Reset
REQ-028 reset shall dominate all inputs, including during COUNT.
REQ-029 Reset values: state=IDLE, finished=1, busy=0, done_pulse=0, remaining=0, prescaler=0.
REQ-030 A reset applied mid-count shall discard the phase with no done_pulse.

Structure
REQ-031 Package phase_timer_pkg shall hold the state enum (IDLE, COUNT) and the default constants TICKS_PER_SEC_DEF=10000 and SEC_W_DEF=16.
REQ-032 One sub-module, sec_prescaler, shall contain the tick counter. Its ports are clk, reset, clr, en, and sec_tick (one-cycle strobe at wrap).
REQ-033 phase_timer shall contain the FSM, the remaining counter, and the output registers.

Verification (TICKS_PER_SEC=10)
REQ-034 Reset -> finished=1, busy=0, remaining=0, done_pulse=0.
REQ-035 start with S=3 -> finished low for 30 cycles; remaining steps 3,2,1 at 10-cycle intervals; finished and done_pulse both high at cycle 30; done_pulse high for 1 cycle.
REQ-036 start with S=0 -> finished stays 1, done_pulse on the next cycle, remaining=0.
REQ-037 S=2 with pause held 5 cycles at cycle 4 -> expiry at cycle 25.
REQ-038 S=4, abort at cycle 12 -> finished=1 and remaining=0 at the next edge, no done_pulse; a start with S=9 during the earlier COUNT is ignored.
REQ-039 S=5, reset at cycle 7 -> all reset values; a back-to-back start on the cycle after a done_pulse is accepted.
